// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared types and constants for the multi-channel FIR MAC (fir_mac_nch).
//   fir_state_e : sequencer states IDLE / RUN / FLUSH / DONE
//   DEF_*       : default widths/sizes used as the top-level parameter defaults
//   sat_slice   : clamp-and-slice of an accumulator, used when FIR_SAT_EN is set
// ---------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  localparam int DEF_NCH        = 2;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_COEF_W     = 16;
  localparam int DEF_NTAPS      = 1021;
  localparam int DEF_ACC_W      = 40;
  localparam int DEF_FRAC_SHIFT = 15;

  // Accumulator arrives sign-extended to 64 bits (ACC_W <= 64). Results above
  // the representable output range clamp to the signed max, below it to the
  // signed min; otherwise the arithmetic shift gives the truncated slice.
  // The caller keeps the low data_w bits of the result.
  function automatic logic [63:0] sat_slice(input logic signed [63:0] acc,
                                            input int                 data_w,
                                            input int                 frac_shift);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    hi    = max_v <<< frac_shift;
    lo    = min_v <<< frac_shift;
    if (acc > hi) begin
      return max_v;
    end else if (acc < lo) begin
      return min_v;
    end
    return acc >>> frac_shift;
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// ---------------------------------------------------------------------------
// fir_coef_rom
// Coefficient ROM shared by all channels, synchronous read (1-cycle latency).
// The storage array mem is filled by the surrounding environment; COEF_FILE
// names the coefficient image and is carried as a parameter only.
// Ports:
//   clk   in   clock
//   addr  in   tap index 0..NTAPS-1
//   dout  out  coefficient for the address presented in the previous cycle
// ---------------------------------------------------------------------------
module fir_coef_rom #(
  parameter int    COEF_W    = 16,
  parameter int    NTAPS     = 1021,
  parameter string COEF_FILE = "B3.hex",
  parameter int    AW        = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  output logic [COEF_W-1:0] dout
);

  logic [COEF_W-1:0] mem [NTAPS];

  always_ff @(posedge clk) begin
    dout <= mem[addr];
  end

endmodule

// File: rtl/fir_mac_nch.sv
// ---------------------------------------------------------------------------
// fir_mac_nch
// NCH-channel FIR filter: one shared coefficient ROM, one time-multiplexed
// MAC lane per channel. A rising edge of `sequencing` starts a run of NTAPS
// taps; the result is registered and announced with a one-cycle smpl_vld.
// Optional feature macro: FIR_SAT_EN (saturate each channel to DATA_W range;
// when undefined the output is a plain truncating bit slice that wraps).
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   sequencing   in   high while the sample queue streams taps
//   smpl_in      in   NCH*DATA_W tap samples, ch0 in LSBs
//   smpl_out     out  NCH*DATA_W filtered results, registered
//   smpl_vld     out  one-cycle pulse when smpl_out updates
//   busy         out  high in RUN and FLUSH
//   dbg_state_o  out  current sequencer state (fir_state_e encoding)
// Output handshake: smpl_vld is a valid-only strobe with no ready; the
// consumer must take smpl_out in the cycle smpl_vld is high. smpl_out holds
// its value between strobes.
// ---------------------------------------------------------------------------
module fir_mac_nch
  import fir_pkg::*;
#(
  parameter int    NCH        = DEF_NCH,
  parameter int    DATA_W     = DEF_DATA_W,
  parameter int    COEF_W     = DEF_COEF_W,
  parameter int    NTAPS      = DEF_NTAPS,
  parameter int    ACC_W      = DEF_ACC_W,
  parameter int    FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter string COEF_FILE  = "B3.hex"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sequencing,
  input  logic [NCH*DATA_W-1:0] smpl_in,
  output logic [NCH*DATA_W-1:0] smpl_out,
  output logic                  smpl_vld,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int            AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int            PW   = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  fir_state_e            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  seq_prev_q;
  logic                  vld_q;
  logic [NCH*DATA_W-1:0] tap_q;
  logic [COEF_W-1:0]     coef;
  logic                  rise;
  logic                  accumulate;
  logic                  clear;
  logic                  load;

  assign rise = sequencing & ~seq_prev_q;

  fir_coef_rom #(
    .COEF_W    (COEF_W),
    .NTAPS     (NTAPS),
    .COEF_FILE (COEF_FILE),
    .AW        (AW)
  ) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .dout (coef)
  );

  // addr_q is the tap index presented this cycle; the sample for the same tap
  // is captured into tap_q at the same edge, so ROM data and tap_q line up one
  // cycle later, which is when the MAC consumes them.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    accumulate = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (rise) begin
          state_d = (addr_q == LAST) ? FLUSH : RUN;
          addr_d  = (addr_q == LAST) ? addr_q : addr_q + AW'(1);
        end
      end
      RUN: begin
        if (!sequencing) begin
          // Early drop: abandon the partial sum, no strobe.
          state_d = IDLE;
          addr_d  = '0;
          clear   = 1'b1;
        end else begin
          accumulate = 1'b1;
          if (addr_q == LAST) begin
            state_d = FLUSH;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      FLUSH: begin
        accumulate = 1'b1;
        load       = 1'b1;
        addr_d     = '0;
        state_d    = sequencing ? DONE : IDLE;
      end
      DONE: begin
        clear = 1'b1;
        if (!sequencing) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      seq_prev_q <= 1'b0;
      vld_q      <= 1'b0;
      tap_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seq_prev_q <= sequencing;
      vld_q      <= load;
      tap_q      <= smpl_in;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    logic signed [DATA_W-1:0] smp;
    logic signed [COEF_W-1:0] cf;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        res;
    logic [DATA_W-1:0]        out_q;

    assign smp  = tap_q[c*DATA_W +: DATA_W];
    assign cf   = coef;
    assign prod = PW'(smp) * PW'(cf);

    always_comb begin
      acc_d = acc_q;
      if (clear) begin
        acc_d = '0;
      end else if (accumulate) begin
        acc_d = acc_q + ACC_W'(prod);
      end
    end

    // The result is taken from acc_d so the final tap lands in smpl_out at
    // the same edge that ends FLUSH.
`ifdef FIR_SAT_EN
    assign res = DATA_W'(sat_slice(64'(acc_d), DATA_W, FRAC_SHIFT));
`else
    assign res = acc_d[FRAC_SHIFT+DATA_W-1:FRAC_SHIFT];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        out_q <= '0;
      end else begin
        acc_q <= acc_d;
        if (load) begin
          out_q <= res;
        end
      end
    end

    assign smpl_out[c*DATA_W +: DATA_W] = out_q;
  end

  assign smpl_vld    = vld_q;
  assign busy        = (state_q == RUN) || (state_q == FLUSH);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_mac_nch.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_nch
// Directed bench for fir_mac_nch with NTAPS=4, NCH=2. Stimulus pushes the
// hand-computed result and its expected strobe cycle into a queue; a monitor
// on the falling edge pops and compares whenever smpl_vld is high.
// ---------------------------------------------------------------------------
module tb_fir_mac_nch;

  localparam int NCH        = 2;
  localparam int DATA_W     = 16;
  localparam int COEF_W     = 16;
  localparam int NTAPS      = 4;
  localparam int ACC_W      = 40;
  localparam int FRAC_SHIFT = 15;
  localparam int W          = NCH * DATA_W;

  // clock / reset
  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         sequencing = 1'b0;
  logic [W-1:0] smpl_in    = '0;
  logic [W-1:0] smpl_out;
  logic         smpl_vld;
  logic         busy;
  logic [1:0]   dbg_state;

  int cycle_cnt = 0;
  int n_vec     = 0;
  int n_fail    = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] tap_v [4];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  fir_mac_nch #(
    .NCH        (NCH),
    .DATA_W     (DATA_W),
    .COEF_W     (COEF_W),
    .NTAPS      (NTAPS),
    .ACC_W      (ACC_W),
    .FRAC_SHIFT (FRAC_SHIFT),
    .COEF_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sequencing  (sequencing),
    .smpl_in     (smpl_in),
    .smpl_out    (smpl_out),
    .smpl_vld    (smpl_vld),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // driver tasks
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp_v, cycle_cnt);
    end
  endtask

  task automatic set_coef(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
    dut.u_rom.mem[0] = c0;
    dut.u_rom.mem[1] = c1;
    dut.u_rom.mem[2] = c2;
    dut.u_rom.mem[3] = c3;
  endtask

  task automatic set_taps(input logic [W-1:0] t0, input logic [W-1:0] t1,
                          input logic [W-1:0] t2, input logic [W-1:0] t3);
    tap_v[0] = t0;
    tap_v[1] = t1;
    tap_v[2] = t2;
    tap_v[3] = t3;
  endtask

  // Holds sequencing high for len cycles starting at cycle n0, feeding tap_v.
  task automatic run_seq(input int len, input bit has_exp, input logic [W-1:0] exp_v);
    int n0;
    int tot;
    tot = (len > 8) ? len : 8;
    n0  = 0;
    for (int i = 0; i < tot; i++) begin
      @(posedge clk); #1;
      sequencing = (i < len);
      smpl_in    = tap_v[(i < 4) ? i : 3];
      if (i == 0) begin
        n0 = cycle_cnt;
        if (has_exp) begin
          exp_q.push_back(exp_v);
          exp_cyc_q.push_back(n0 + NTAPS + 1);
        end
      end
      @(negedge clk);
      if (len >= NTAPS) begin
        if (i == 2) check("busy_in_run", W'(busy), W'(1));
        if (i == 6) check("busy_after_run", W'(busy), W'(0));
      end else begin
        if (i == 1) check("busy_before_abort", W'(busy), W'(1));
        if (i == 3) check("busy_after_abort", W'(busy), W'(0));
      end
    end
    @(posedge clk); #1;
    sequencing = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           ec;
    if (rst_n && smpl_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_vld: got strobe at cycle %0d, want none (out %h)", cycle_cnt, smpl_out);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("smpl_out", smpl_out, e);
        check("vld_cycle", W'(cycle_cnt), W'(ec));
      end
    end
  end

  initial begin
    set_coef(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    set_taps(32'hF000_1000, 32'hF000_1000, 32'hF000_1000, 32'hF000_1000);

    // reset with sequencing toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sequencing = ~sequencing;
      smpl_in    = 32'h1234_5678;
    end
    @(negedge clk);
    check("rst_out", smpl_out, '0);
    check("rst_vld", W'(smpl_vld), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    @(posedge clk); #1;
    sequencing = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_out", smpl_out, '0);
    check("post_rst_busy", W'(busy), W'(0));

    // basic run
    run_seq(4, 1'b1, 32'hE000_2000);

    // abort after two cycles: no strobe, output holds
    set_taps(32'h0100_0100, 32'h0100_0100, 32'h0100_0100, 32'h0100_0100);
    run_seq(2, 1'b0, '0);
    check("abort_hold", smpl_out, 32'hE000_2000);

    // full run after abort
    set_taps(32'hF000_0800, 32'hF000_0800, 32'hF000_0800, 32'hF000_0800);
    run_seq(4, 1'b1, 32'hE000_1000);

    // distinct coefficients and samples per tap (tap ordering)
    set_coef(16'h4000, 16'h2000, 16'h1000, 16'h0800);
    set_taps(32'h0100_1000, 32'hFF00_2000, 32'h0200_3000, 32'h0000_4000);
    run_seq(4, 1'b1, 32'h0080_1A00);

    // truncation: -16384>>15 floors to -1, +16384>>15 to 0
    set_coef(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    set_taps(32'hFFFF_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    run_seq(4, 1'b1, 32'hFFFF_0000);

    // sequencing held 10 cycles, then identical rerun (no carry-over)
    set_taps(32'h0C00_0400, 32'h0C00_0400, 32'h0C00_0400, 32'h0C00_0400);
    run_seq(10, 1'b1, 32'h1800_0800);
    run_seq(4, 1'b1, 32'h1800_0800);

    // overflow
    set_coef(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    set_taps(32'h8000_7FFF, 32'h8000_7FFF, 32'h8000_7FFF, 32'h8000_7FFF);
`ifdef FIR_SAT_EN
    run_seq(4, 1'b1, 32'h8000_7FFF);
`else
    run_seq(4, 1'b1, 32'h0004_FFF8);
`endif

    // reset asserted at n0+2
    set_coef(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    set_taps(32'hF000_1000, 32'hF000_1000, 32'hF000_1000, 32'hF000_1000);
    @(posedge clk); #1;
    sequencing = 1'b1;
    smpl_in    = tap_v[0];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", smpl_out, '0);
    check("midrst_vld", W'(smpl_vld), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1;
    sequencing = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_seq(4, 1'b1, 32'hE000_2000);

    repeat (4) @(posedge clk);
    check("pending_results", W'(exp_q.size()), W'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
